mips_alu: RTL and testbench

Combinational 32-bit integer ALU for the execute stage of the pipelined MIPS datapath. It performs AND, OR, ADD, SUB, SLT and the two shifts (SLL, SRL) selected by a 4-bit control code from the ALU decoder, and produces a result plus a zero flag for branch resolution. A single clocked register holds a sticky illegal-opcode flag for debug.

---
 rtl/mips_alu_if.sv | 23 ++
 rtl/mips_alu.sv | 74 +++++++
 tb/tb_mips_alu.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_alu_if.sv
//------------------------------------------------------------------------------
// Module   : mips_alu_if
// Brief    : Operand/control/result bundle between the execute stage and the ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mips_alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  F;
    logic [4:0]  shamt;
    logic [31:0] Y;
    logic        zero;
    logic        badop;

    modport master (output A, output B, output F, output shamt,
                    input  Y, input  zero, input  badop);
    modport slave  (input  A, input  B, input  F, input  shamt,
                    output Y, output zero, output badop);
endinterface

`default_nettype wire

// File: rtl/mips_alu.sv
//------------------------------------------------------------------------------
// Module   : mips_alu
// Brief    : 32-bit MIPS execute-stage ALU with sticky illegal-opcode flag.
//            Optional shifter enabled by defining MIPS_ALU_SHIFT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_alu (
    input  wire logic   clk,
    input  wire logic   reset,
    mips_alu_if.slave   bus
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b1010;
    localparam logic [3:0] c_OP_SLT = 4'b1011;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic [31:0] w_y;
    logic        w_illegal;
    logic        r_badop;

    // Mixed signs: the negative operand is the smaller; same sign: unsigned compare.
    assign w_sum  = bus.A + bus.B;
    assign w_diff = bus.A - bus.B;
    assign w_slt  = (bus.A[31] != bus.B[31]) ? bus.A[31] : (bus.A < bus.B);

    always_comb begin
        w_y       = 32'h0;
        w_illegal = 1'b0;
        case (bus.F)
            c_OP_AND: w_y = bus.A & bus.B;
            c_OP_OR:  w_y = bus.A | bus.B;
            c_OP_ADD: w_y = w_sum;
`ifdef MIPS_ALU_SHIFT_EN
            c_OP_SLL: w_y = w_sum << bus.shamt;
            c_OP_SRL: w_y = w_sum >> bus.shamt;
`else
            c_OP_SLL: w_illegal = 1'b1;
            c_OP_SRL: w_illegal = 1'b1;
`endif
            c_OP_SUB: w_y = w_diff;
            c_OP_SLT: w_y = {31'h0, w_slt};
            default:  w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_badop <= 1'b0;
        end else if (w_illegal) begin
            r_badop <= 1'b1;
        end
    end

    assign bus.Y     = w_y;
    assign bus.zero  = (w_y == 32'h0);
    assign bus.badop = r_badop;

`ifndef MIPS_ALU_SHIFT_EN
    logic w_unused_shamt;
    assign w_unused_shamt = ^bus.shamt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_alu.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_alu
// Brief    : Self-checking bench for mips_alu: directed cases plus random ops
//            against a behavioural reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_alu;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic m_badop;

    mips_alu_if u_if ();

    mips_alu u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] f);
`ifdef MIPS_ALU_SHIFT_EN
        return (f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd10, 4'd11});
`else
        return (f inside {4'd0, 4'd1, 4'd2, 4'd10, 4'd11});
`endif
    endfunction

    function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f, input logic [4:0] sh);
        logic [31:0] s;
        s = a + b;
        if (!ref_legal(f)) return 32'h0;
        case (f)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return s;
            4'd4:    return s << sh;
            4'd5:    return s >> sh;
            4'd10:   return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, check combinational outputs, then the flag after the edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                         input logic [4:0] sh, input logic rst, input string tag);
        logic [31:0] e;
        @(negedge clk);
        u_if.A = a; u_if.B = b; u_if.F = f; u_if.shamt = sh; reset = rst;
        #1;
        e = ref_y(a, b, f, sh);
        chk({tag, ".Y"}, u_if.Y, e);
        chk({tag, ".zero"}, {31'h0, u_if.zero}, {31'h0, (e == 32'h0)});
        @(posedge clk);
        if (rst) m_badop = 1'b0;
        else if (!ref_legal(f)) m_badop = 1'b1;
        #1;
        chk({tag, ".badop"}, {31'h0, u_if.badop}, {31'h0, m_badop});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_badop  = 1'b0;
        reset    = 1'b1;
        u_if.A = '0; u_if.B = '0; u_if.F = 4'd0; u_if.shamt = '0;

        apply(32'h0, 32'h0, 4'b0011, 5'd0, 1'b1, "rst_wins");
        apply(32'hFFFF_FFFF, 32'h1, 4'b0010, 5'd0, 1'b0, "add_wrap");
        apply(32'h1234_5678, 32'h1111_1111, 4'b0010, 5'd0, 1'b0, "add");
        apply(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1010, 5'd0, 1'b0, "sub_eq");
        apply(32'hFFFF_FFFF, 32'h1, 4'b1011, 5'd0, 1'b0, "slt_neg");
        apply(32'h1, 32'h8000_0000, 4'b1011, 5'd0, 1'b0, "slt_min");
        apply(32'd5, 32'd7, 4'b1011, 5'd0, 1'b0, "slt_pos");
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 5'd0, 1'b0, "and");
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 5'd0, 1'b0, "or");
        apply(32'h1, 32'h2, 4'b0100, 5'd4, 1'b0, "sll");
        apply(32'h8000_0000, 32'h0, 4'b0101, 5'd31, 1'b0, "srl");
        apply(32'h1234_0000, 32'h5678, 4'b0100, 5'd0, 1'b0, "sll0");
        apply(32'h0, 32'h0, 4'b0010, 5'd0, 1'b1, "rst_clr");
        apply(32'h1, 32'h1, 4'b0011, 5'd3, 1'b0, "ill_0011");
        apply(32'h1, 32'h1, 4'b0010, 5'd0, 1'b0, "sticky");
        apply(32'h1, 32'h1, 4'b0010, 5'd0, 1'b1, "rst_again");

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = -a;
                default: ;
            endcase
            f = ($urandom_range(0, 7) == 0) ? 4'($urandom) :
                4'(($urandom_range(0, 6) == 0) ? 4 :
                   (4'd0 + 4'($urandom_range(0, 1)) * 4'd10 + 4'($urandom_range(0, 1)) +
                    (($urandom_range(0, 2) == 0) ? 4'd4 : 4'd0)));
            apply(a, b, f, 5'($urandom), ($urandom_range(0, 9) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
